// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words over valid/ready and
// emits one registered bit per clock, with a one-word holding register for gapless streaming.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             xout,
    output logic             xout_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;
    logic             xout_q, xout_d;
    logic             xout_valid_q, xout_valid_d;
    logic             last_q, last_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             xfer;

    // Bit that leaves first from a word, and the word with that bit removed.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign xfer = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        hold_full_d  = hold_full_q;
        xout_d       = xout_q;
        xout_valid_d = xout_valid_q;
        last_d       = last_q;

        if (state_q == ST_IDLE) begin
            if (xfer) begin
                xout_d       = first_bit(in_data);
                sh_d         = drop_bit(in_data);
                cnt_d        = CW'(WIDTH - 1);
                xout_valid_d = 1'b1;
                last_d       = 1'b0;
                state_d      = ST_SHIFT;
            end else begin
                xout_d       = IDLE_BIT;
                xout_valid_d = 1'b0;
                last_d       = 1'b0;
            end
        end else if (cnt_q != '0) begin
            xout_d = first_bit(sh_q);
            sh_d   = drop_bit(sh_q);
            cnt_d  = cnt_q - CW'(1);
            last_d = (cnt_q == CW'(1));
            if (xfer) begin
                hold_d      = in_data;
                hold_full_d = 1'b1;
            end
        end else if (hold_full_q) begin
            // Final bit shown; the held word follows with no gap.
            xout_d       = first_bit(hold_q);
            sh_d         = drop_bit(hold_q);
            cnt_d        = CW'(WIDTH - 1);
            xout_valid_d = 1'b1;
            last_d       = 1'b0;
            hold_full_d  = 1'b0;
        end else if (xfer) begin
            xout_d       = first_bit(in_data);
            sh_d         = drop_bit(in_data);
            cnt_d        = CW'(WIDTH - 1);
            xout_valid_d = 1'b1;
            last_d       = 1'b0;
        end else begin
            xout_d       = IDLE_BIT;
            xout_valid_d = 1'b0;
            last_d       = 1'b0;
            state_d      = ST_IDLE;
        end

        in_ready_d = !hold_full_d;
        busy_d     = (state_d == ST_SHIFT) || hold_full_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sh_q         <= '0;
            hold_q       <= '0;
            cnt_q        <= '0;
            hold_full_q  <= 1'b0;
            xout_q       <= IDLE_BIT;
            xout_valid_q <= 1'b0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            hold_full_q  <= hold_full_d;
            xout_q       <= xout_d;
            xout_valid_q <= xout_valid_d;
            last_q       <= last_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign xout       = xout_q;
    assign xout_valid = xout_valid_q;
    assign last       = last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first/idle-0 and an LSB-first/idle-1 instance
// share stimulus and are compared against a bit-queue reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;

    logic rdy_m, xout_m, xv_m, last_m, busy_m;
    logic rdy_l, xout_l, xv_l, last_l, busy_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_m), .xout(xout_m), .xout_valid(xv_m), .last(last_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_l), .xout(xout_l), .xout_valid(xv_l), .last(last_l), .busy(busy_l)
    );

    // Reference model: every accepted word queues 8 pending bits; each edge emits the oldest one.
    typedef struct {
        logic [7:0] w;
        int         idx;
    } pend_t;

    pend_t q[$];
    logic  exp_x_m, exp_x_l, exp_xv, exp_last, exp_ready, exp_busy;

    always @(posedge clk or negedge reset_n) begin
        pend_t e;
        if (!reset_n) begin
            q.delete();
            exp_x_m = 1'b0; exp_x_l = 1'b1; exp_xv = 1'b0;
            exp_last = 1'b0; exp_ready = 1'b1; exp_busy = 1'b0;
        end else begin
            if (in_valid && exp_ready)
                for (int i = 0; i < 8; i++) q.push_back('{w: in_data, idx: i});
            if (q.size() > 0) begin
                e = q.pop_front();
                exp_xv = 1'b1;
                exp_x_m = e.w[7 - e.idx];
                exp_x_l = e.w[e.idx];
                exp_last = (e.idx == 7);
            end else begin
                exp_xv = 1'b0; exp_x_m = 1'b0; exp_x_l = 1'b1; exp_last = 1'b0;
            end
            exp_ready = (q.size() < 8);
            exp_busy = exp_xv || (q.size() >= 8);
        end
    end

    function automatic logic [9:0] got();
        return {xout_m, xv_m, last_m, rdy_m, busy_m, xout_l, xv_l, last_l, rdy_l, busy_l};
    endfunction

    function automatic logic [9:0] want();
        return {exp_x_m, exp_xv, exp_last, exp_ready, exp_busy,
                exp_x_l, exp_xv, exp_last, exp_ready, exp_busy};
    endfunction

    // Drive inputs on the falling edge, then sample 1 ns after the next rising edge.
    task automatic cycle(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got() !== 10'b00010_10010) begin
            errors++; $display("FAIL reset_state got %b want %b", got(), 10'b00010_10010);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 8'h00);
            checks++;
            if (got() !== want()) begin
                errors++; $display("FAIL reset_idle cyc %0d got %b want %b", c, got(), want());
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] bits_m = '0;
        int n = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(c == 0, 8'b1001_0110);
            checks++;
            if (got() !== want()) begin
                errors++; $display("FAIL single cyc %0d got %b want %b", c, got(), want());
            end
            if (xv_m && n < 8) begin bits_m = {bits_m[6:0], xout_m}; n++; end
        end
        checks++;
        if (bits_m !== 8'b1001_0110 || n != 8) begin
            errors++; $display("FAIL single_seq got %b (%0d bits) want 10010110", bits_m, n);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  words[3] = '{8'hA5, 8'h3C, 8'hFF};
        logic [23:0] bits_m = '0;
        int sent = 0, nvalid = 0, rises = 0, nlast = 0;
        logic prev_xv = 1'b0;
        for (int c = 0; c < 30; c++) begin
            cycle(sent < 3, (sent < 3) ? words[sent] : 8'h00);
            if (in_valid && exp_ready_before(c)) sent++;
            checks++;
            if (got() !== want()) begin
                errors++; $display("FAIL b2b cyc %0d got %b want %b", c, got(), want());
            end
            if (xv_m) begin bits_m = {bits_m[22:0], xout_m}; nvalid++; end
            if (xv_m && !prev_xv) rises++;
            if (last_m) nlast++;
            prev_xv = xv_m;
        end
        checks++;
        if (bits_m !== 24'hA53CFF || nvalid != 24 || rises != 1 || nlast != 3) begin
            errors++;
            $display("FAIL b2b_stream got %h valid=%0d bursts=%0d lasts=%0d want a53cff 24 1 3",
                     bits_m, nvalid, rises, nlast);
        end
    endtask

    // Transfer bookkeeping for the back-to-back driver: the model records acceptances.
    int   acc_count = 0;
    int   acc_seen  = 0;
    always @(posedge clk) if (reset_n && in_valid && exp_ready) acc_count <= acc_count + 1;

    function automatic bit exp_ready_before(input int c);
        bit r = (acc_count != acc_seen);
        acc_seen = acc_count;
        return r && (c >= 0);
    endfunction

    task automatic test_lsb();
        logic [7:0] seq_l = '0;
        int n = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(c == 0, 8'b0000_1001);
            checks++;
            if (got() !== want()) begin
                errors++; $display("FAIL lsb cyc %0d got %b want %b", c, got(), want());
            end
            if (xv_l && n < 8) begin seq_l[n] = xout_l; n++; end
        end
        checks++;
        if (seq_l !== 8'b0000_1001 || n != 8) begin
            errors++; $display("FAIL lsb_seq got %b (%0d bits) want 00001001", seq_l, n);
        end
    endtask

    task automatic test_gap();
        int   idle = 0;
        logic rdy_all = 1'b1;
        for (int c = 0; c < 21; c++) begin
            cycle(c == 0 || c == 11, 8'h81);
            checks++;
            if (got() !== want()) begin
                errors++; $display("FAIL gap cyc %0d got %b want %b", c, got(), want());
            end
            if (c >= 1 && c <= 10 && !xv_m && xout_m == 1'b0 && !xv_l && xout_l == 1'b1) idle++;
            rdy_all &= rdy_m & rdy_l;
        end
        checks++;
        if (idle != 3 || rdy_all !== 1'b1) begin
            errors++; $display("FAIL gap_idle got idle=%0d ready=%b want 3 1", idle, rdy_all);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 8'hF0);
        cycle(1'b1, 8'h0F);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        checks++;
        if ({xout_m, xv_m, rdy_m, busy_m} !== 4'b1101) begin
            errors++; $display("FAIL mid_pre got %b want 1101", {xout_m, xv_m, rdy_m, busy_m});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (got() !== 10'b00010_10010) begin
            errors++; $display("FAIL mid_reset got %b want %b", got(), 10'b00010_10010);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            cycle(c == 3, 8'h3C);
            checks++;
            if (got() !== want()) begin
                errors++; $display("FAIL mid_after cyc %0d got %b want %b", c, got(), want());
            end
        end
    endtask

    task automatic test_hold_boundary();
        for (int c = 0; c < 8; c++) cycle(c == 0, 8'h5A);
        cycle(1'b1, 8'hC3);
        checks++;
        if ({xout_m, xv_m, last_m, rdy_m, busy_m} !== 5'b11011) begin
            errors++;
            $display("FAIL hold_edge got %b want 11011", {xout_m, xv_m, last_m, rdy_m, busy_m});
        end
        for (int c = 0; c < 9; c++) begin
            cycle(1'b0, 8'h00);
            checks++;
            if (got() !== want()) begin
                errors++; $display("FAIL hold_tail cyc %0d got %b want %b", c, got(), want());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom));
            checks++;
            if (got() !== want()) begin
                errors++; $display("FAIL random cyc %0d got %b want %b", c, got(), want());
            end
        end
        for (int c = 0; c < 20; c++) begin
            cycle(1'b0, 8'h00);
            checks++;
            if (got() !== want()) begin
                errors++; $display("FAIL drain cyc %0d got %b want %b", c, got(), want());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb();
        test_gap();
        test_reset_mid();
        test_hold_boundary();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
